// File: rtl/inst_fetch_resp.sv
// Fetch responder: accepts fetch PCs from IF, issues them on the SRAM-like
// instruction bus, pairs each returned word with its PC in request order and
// buffers {pc, inst} pairs for ID behind a valid/ready handshake.
//
// Handshakes:
//   IF  side : a PC is taken in any cycle where req_valid & req_ready.
//   bus side : inst_req/inst_addr_ok accept an address, inst_data_ok returns
//              one word per cycle in address-accept order.
//   ID  side : the head entry is consumed in any cycle where out_valid & out_ready.
// A flush drops everything buffered plus every word still owed by the bus.
module inst_fetch_resp #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              req_ready,
    input  logic              flush,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [31:0]       inst_rdata,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_inst,
    input  logic              out_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]     r_pend_cnt;
    logic [CW-1:0]     r_out_cnt;
    logic [CW-1:0]     r_disc_cnt;
    logic [PW-1:0]     r_pend_wp;
    logic [PW-1:0]     r_pend_rp;
    logic [PW-1:0]     r_out_wp;
    logic [PW-1:0]     r_out_rp;
    logic [ADDR_W-1:0] r_pend_pc  [DEPTH];
    logic [ADDR_W-1:0] r_out_pc   [DEPTH];
    logic [31:0]       r_out_inst [DEPTH];

    logic [CW+1:0]     w_sum;
    logic              w_credit;
    logic              w_accept;
    logic              w_drop;
    logic              w_take;
    logic              w_out_pop;
    logic              w_flush_dok;
    logic [CW-1:0]     w_flush_disc;

    // Every in-flight or buffered entry holds a credit, so the output FIFO
    // always has room for each word the bus may still return.
    assign w_sum    = {2'b00, r_disc_cnt} + {2'b00, r_pend_cnt} + {2'b00, r_out_cnt};
    assign w_credit = (w_sum < (CW+2)'(DEPTH));

    assign inst_req  = rst & req_valid & w_credit & ~flush;
    assign inst_addr = req_pc;
    assign req_ready = inst_req & inst_addr_ok;
    assign w_accept  = req_ready;

    // Owed-but-flushed words are dropped first; a word with nothing pending
    // and nothing to discard is a bus protocol error and is ignored.
    assign w_drop = inst_data_ok & (r_disc_cnt != '0);
    assign w_take = inst_data_ok & (r_disc_cnt == '0) & (r_pend_cnt != '0);

    assign out_valid = (r_out_cnt != '0);
    assign out_pc    = r_out_pc[r_out_rp];
    assign out_inst  = r_out_inst[r_out_rp];
    assign w_out_pop = out_valid & out_ready;

    // On flush every pending PC becomes a discard; the word arriving in the
    // flush cycle itself is dropped, guarded so the count cannot underflow.
    assign w_flush_dok  = inst_data_ok & ((r_disc_cnt != '0) | (r_pend_cnt != '0));
    assign w_flush_disc = r_disc_cnt + r_pend_cnt - CW'(w_flush_dok);

    // Pending-PC FIFO storage: written on accept, read at the head on a take.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pend_pc[r_pend_wp] <= req_pc;
        end
    end

    // Pending-PC FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_wp  <= '0;
            r_pend_rp  <= '0;
            r_pend_cnt <= '0;
        end else if (flush) begin
            r_pend_wp  <= '0;
            r_pend_rp  <= '0;
            r_pend_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_pend_wp <= r_pend_wp + PW'(1);
            end
            if (w_take) begin
                r_pend_rp <= r_pend_rp + PW'(1);
            end
            r_pend_cnt <= r_pend_cnt + CW'(w_accept) - CW'(w_take);
        end
    end

    // Output FIFO: {pc, inst} pairs for ID; storage is reset so the head reads 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_wp  <= '0;
            r_out_rp  <= '0;
            r_out_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_out_pc[i]   <= '0;
                r_out_inst[i] <= '0;
            end
        end else if (flush) begin
            r_out_wp  <= '0;
            r_out_rp  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_take) begin
                r_out_pc[r_out_wp]   <= r_pend_pc[r_pend_rp];
                r_out_inst[r_out_wp] <= inst_rdata;
                r_out_wp             <= r_out_wp + PW'(1);
            end
            if (w_out_pop) begin
                r_out_rp <= r_out_rp + PW'(1);
            end
            r_out_cnt <= r_out_cnt + CW'(w_take) - CW'(w_out_pop);
        end
    end

    // Discard counter: loaded on flush, drained one per dropped word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_disc_cnt <= '0;
        end else if (flush) begin
            r_disc_cnt <= w_flush_disc;
        end else if (w_drop) begin
            r_disc_cnt <= r_disc_cnt - CW'(1);
        end
    end

endmodule

// File: doc/inst_fetch_resp.md
Name: inst_fetch_resp

Overview:
- Responder side of the fetch interface driven by the PC register.
- Accepts fetch-PC requests from IF and issues them on the SRAM-like instruction bus (inst_req/addr_ok/data_ok).
- Tracks in-flight PCs in order, pairs each returned word with its PC, and buffers {pc, inst} pairs for ID through a valid/ready handshake.
- Handles pipeline flush by discarding responses still owed by the bus.

Parameters:
DEPTH, 4, max entries in flight plus buffered (pending-PC FIFO and output FIFO each sized DEPTH); power of 2, ≥2
ADDR_W, 32, PC / address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  IF presents a fetch PC
req_pc  in  ADDR_W  fetch PC (IF_PC)
req_ready  out  1  request accepted this cycle; IF advances PC (drives PC_Wr)
flush  in  1  redirect/exception; drop everything older than next request
inst_req  out  1  bus request
inst_addr  out  ADDR_W  bus address (= req_pc)
inst_addr_ok  in  1  bus accepted address
inst_data_ok  in  1  bus returns one word, in request order
inst_rdata  in  32  returned instruction
out_valid  out  1  {out_pc, out_inst} valid to ID
out_pc  out  ADDR_W  PC of buffered instruction
out_inst  out  32  buffered instruction
out_ready  in  1  ID consumes head entry

Behaviour:
- Counters: pend_cnt (pending-PC FIFO occupancy), out_cnt (output FIFO occupancy), disc_cnt (responses to drop); each $clog2(DEPTH)+1 bits.
- credit = (disc_cnt + pend_cnt + out_cnt) < DEPTH. The output FIFO can therefore never overflow.
- Request path, combinational:
  - inst_req = req_valid & credit & ~flush.
  - inst_addr = req_pc.
  - req_ready = inst_req & inst_addr_ok.
- Accept: on req_ready, push req_pc into the pending-PC FIFO.
- Response path: on inst_data_ok,
  - if disc_cnt != 0, decrement disc_cnt and drop the word;
  - else pop the pending-PC head and push {pc, inst_rdata} into the output FIFO.
- data_ok with disc_cnt = 0 and pend_cnt = 0 is a protocol error: ignore it; counters must not underflow.
- Output: out_valid = (out_cnt != 0), registered state. out_pc/out_inst show the FIFO head.
  - Pop when out_valid & out_ready.
  - Latency: data_ok at cycle t → out_valid at t+1. No bypass.
- Simultaneous events:
  - push and pop of the same FIFO in one cycle: occupancy unchanged. Legal when full for the output FIFO, and when the pending FIFO is at DEPTH.
  - accept and data_ok in the same cycle: both take effect.
- Flush, in its cycle:
  - inst_req = 0 and req_ready = 0.
  - Output FIFO cleared; out_valid = 0 from t+1, and ID pop is ignored.
  - Pending FIFO cleared (pointers reset).
  - disc_cnt_next = disc_cnt + pend_cnt − inst_data_ok; the data_ok in the flush cycle is always dropped.
  - Requests resume at t+1; the first new request is subject to credit, which includes disc_cnt.
- FIFO pointers wrap modulo DEPTH.
- Reset (async, any time incl. mid-transaction):
  - All counters and pointers = 0.
  - out_valid = 0, out_pc = 0, out_inst = 0.
  - inst_req = 0 while rst low.
  - The bus is expected to be reset simultaneously; no discard carry-over.

Test Plan:
1. Single fetch: req_pc=0xBFC00000, addr_ok same cycle, data_ok 2 cycles later with 0x24080001 → one cycle later out_valid=1, out_pc=0xBFC00000, out_inst=0x24080001; out_ready=1 → out_valid=0.
2. Backpressure: out_ready=0, addr_ok/data_ok always 1, PCs 0x0,0x4,0x8,0xC,… → exactly 4 accepts, then req_ready=0. One out_ready pulse → pops 0x0, one more accept (0x10). Order preserved.
3. Flush with 2 outstanding (PCs 0x100, 0x104 accepted, no data yet) → disc_cnt=2, out FIFO empty. Next two data_ok words dropped. New PC 0x200's word then appears with out_pc=0x200.
4. Flush coincident with data_ok and pend_cnt=3 → disc_cnt=2, out_valid=0 next cycle. Credit blocks the 3rd new request until the discards drain (with DEPTH=4 and 2 new pending).
5. Output FIFO full (out_cnt=4 via pending=0) with out_ready=1 and a data_ok same cycle: illegal by credit. Verify instead out_cnt=3, pend_cnt=1, data_ok+pop together → out_cnt stays 3, no overflow, order intact.
6. Reset asserted mid-run with 3 pending and 2 buffered → out_valid=0, out_pc=0, inst_req=0 immediately. After release a fresh fetch completes as in test 1.
